// File: rtl/rename_ckpt_pkg.sv
// rtl/rename_ckpt_pkg.sv - shared rename types, widths and map helper
package rename_ckpt_pkg;

  localparam int NUM_AREGS     = 32;
  localparam int AREG_W        = 5;
  localparam int NUM_PREGS_DEF = 64;
  localparam int PREG_W        = $clog2(NUM_PREGS_DEF);

  typedef logic [AREG_W-1:0] areg_idx_t;
  typedef logic [PREG_W-1:0] preg_idx_t;
  typedef logic [NUM_AREGS-1:0][PREG_W-1:0] map_t;

  typedef struct packed {
    logic      valid;
    areg_idx_t idx;
  } a_reg_t;

  typedef struct packed {
    logic   valid;
    a_reg_t rd;
    a_reg_t rs1;
    a_reg_t rs2;
    logic   is_branch;
  } dinstr_t;

  typedef struct packed {
    logic      valid;
    preg_idx_t idx;
  } p_reg_t;

  typedef struct packed {
    logic      valid;
    preg_idx_t idx;
    logic      ready;
  } p_src_t;

  typedef struct packed {
    logic   valid;
    p_reg_t rd;
    p_src_t rs1;
    p_src_t rs2;
  } rinstr_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;

  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < NUM_AREGS; i++) begin
      m[i] = PREG_W'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/rename_freelist.sv
// rtl/rename_freelist.sv - free physical register bitmap with lowest-index allocator
module rename_freelist
  import rename_ckpt_pkg::*;
#(
  parameter int NUM_PREGS = NUM_PREGS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 alloc_i,
  input  logic                 release_i,
  input  preg_idx_t            release_idx_i,
  input  logic [NUM_PREGS-1:0] restore_i,
  output preg_idx_t            alloc_idx_o,
  output logic                 empty_o
);

  logic [NUM_PREGS-1:0] free_q, free_d;

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    alloc_idx_o = '0;
    for (int i = NUM_PREGS - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        alloc_idx_o = PREG_W'(i);
      end
    end
    empty_o = ~|free_q;
  end

  always_comb begin
    free_d = free_q;
    if (alloc_i) begin
      free_d[alloc_idx_o] = 1'b0;
    end
    if (release_i && (release_idx_i != '0)) begin
      free_d[release_idx_i] = 1'b1;
    end
    free_d = free_d | restore_i;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      free_q <= {{(NUM_PREGS - NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
    end else begin
      free_q <= free_d;
    end
  end

endmodule

// File: rtl/rename_ckpt.sv
// rtl/rename_ckpt.sv - register rename with FIFO branch checkpoints and mispredict recovery
// Build option RENAME_COMMIT_BYPASS_EN forwards same-cycle writebacks into source ready bits.
module rename_ckpt
  import rename_ckpt_pkg::*;
#(
  parameter int NUM_PREGS = NUM_PREGS_DEF,
  parameter int NUM_CKPT  = 4
) (
  input  logic       clk,
  input  logic       rst_i,
  input  dinstr_t    dinstr_i,
  input  p_reg_t     p_commit_i,
  input  p_reg_t     p_free_i,
  input  br_result_t br_result_i,
  output rinstr_t    rinstr_o,
  output logic       rn_full_o
);

  localparam int CKPT_PW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
  localparam int CKPT_CW = $clog2(NUM_CKPT + 1);
`ifdef RENAME_COMMIT_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  map_t                 map_q, map_d;
  logic [NUM_PREGS-1:0] ready_q, ready_d;
  map_t                 ckpt_map_q   [NUM_CKPT];
  map_t                 ckpt_map_d   [NUM_CKPT];
  logic [NUM_PREGS-1:0] ckpt_alloc_q [NUM_CKPT];
  logic [NUM_PREGS-1:0] ckpt_alloc_d [NUM_CKPT];
  logic [NUM_CKPT-1:0]  ckpt_vld_q, ckpt_vld_d;
  logic [CKPT_PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CKPT_CW-1:0]   cnt_q, cnt_d;

  preg_idx_t            alloc_idx;
  logic                 free_empty;
  logic [NUM_PREGS-1:0] restore_mask;
  logic                 ckpt_any, br_hit, br_miss;
  logic                 accept, rd_alloc, do_alloc, do_push;
  p_src_t               src1, src2;

  function automatic logic [CKPT_PW-1:0] ptr_inc(input logic [CKPT_PW-1:0] p);
    return (p == CKPT_PW'(NUM_CKPT - 1)) ? '0 : p + CKPT_PW'(1);
  endfunction

  function automatic p_src_t resolve(input a_reg_t rs, input map_t map,
                                     input logic [NUM_PREGS-1:0] rdy, input p_reg_t cmt);
    p_src_t s;
    s.valid = rs.valid;
    s.idx   = (rs.idx == '0) ? '0 : map[rs.idx];
    s.ready = (rs.idx == '0) | rdy[s.idx] | (BYPASS_EN & cmt.valid & (cmt.idx == s.idx));
    return s;
  endfunction

  rename_freelist #(
    .NUM_PREGS(NUM_PREGS)
  ) u_freelist (
    .clk          (clk),
    .rst_i        (rst_i),
    .alloc_i      (do_alloc),
    .release_i    (p_free_i.valid),
    .release_idx_i(p_free_i.idx),
    .restore_i    (restore_mask),
    .alloc_idx_o  (alloc_idx),
    .empty_o      (free_empty)
  );

  // Branch results arriving with no live checkpoint are dropped entirely.
  always_comb begin
    ckpt_any  = (cnt_q != '0);
    br_hit    = br_result_i.valid & br_result_i.hit & ckpt_any;
    br_miss   = br_result_i.valid & ~br_result_i.hit & ckpt_any;
    rn_full_o = rst_i | free_empty | (cnt_q == CKPT_CW'(NUM_CKPT));
    accept    = dinstr_i.valid & ~rn_full_o & ~br_miss;
    rd_alloc  = dinstr_i.rd.valid & (dinstr_i.rd.idx != '0);
    do_alloc  = accept & rd_alloc;
    do_push   = accept & dinstr_i.is_branch;
    src1      = resolve(dinstr_i.rs1, map_q, ready_q, p_commit_i);
    src2      = resolve(dinstr_i.rs2, map_q, ready_q, p_commit_i);

    rinstr_o.valid    = accept;
    rinstr_o.rd.valid = rd_alloc;
    rinstr_o.rd.idx   = alloc_idx;
    rinstr_o.rs1      = src1;
    rinstr_o.rs2      = src2;
  end

  // The oldest checkpoint's alloc-since already covers younger ones; OR-ing all is equivalent.
  always_comb begin
    restore_mask = '0;
    if (br_miss) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        if (ckpt_vld_q[i]) begin
          restore_mask = restore_mask | ckpt_alloc_q[i];
        end
      end
    end
  end

  always_comb begin
    map_d        = map_q;
    ready_d      = ready_q;
    ckpt_map_d   = ckpt_map_q;
    ckpt_alloc_d = ckpt_alloc_q;
    ckpt_vld_d   = ckpt_vld_q;
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q;

    if (do_alloc) begin
      map_d[dinstr_i.rd.idx] = alloc_idx;
      ready_d[alloc_idx]     = 1'b0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        if (ckpt_vld_q[i]) begin
          ckpt_alloc_d[i][alloc_idx] = 1'b1;
        end
      end
    end

    if (p_commit_i.valid && (p_commit_i.idx != '0)) begin
      ready_d[p_commit_i.idx] = 1'b1;
    end

    if (br_hit) begin
      ckpt_vld_d[head_q] = 1'b0;
      head_d             = ptr_inc(head_q);
    end

    // Snapshot taken after the branch's own destination update.
    if (do_push) begin
      ckpt_map_d[tail_q]   = map_d;
      ckpt_alloc_d[tail_q] = '0;
      ckpt_vld_d[tail_q]   = 1'b1;
      tail_d               = ptr_inc(tail_q);
    end

    if (do_push && !br_hit) begin
      cnt_d = cnt_q + CKPT_CW'(1);
    end else if (br_hit && !do_push) begin
      cnt_d = cnt_q - CKPT_CW'(1);
    end

    if (br_miss) begin
      map_d      = ckpt_map_q[head_q];
      ready_d    = ready_d | restore_mask;
      ckpt_vld_d = '0;
      head_d     = '0;
      tail_d     = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      map_q      <= identity_map();
      ready_q    <= '1;
      ckpt_vld_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        ckpt_map_q[i]   <= '0;
        ckpt_alloc_q[i] <= '0;
      end
    end else begin
      map_q        <= map_d;
      ready_q      <= ready_d;
      ckpt_map_q   <= ckpt_map_d;
      ckpt_alloc_q <= ckpt_alloc_d;
      ckpt_vld_q   <= ckpt_vld_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rename_ckpt.sv
// tb/tb_rename_ckpt.sv - directed and scoreboarded checks for rename_ckpt
module tb_rename_ckpt;
  import rename_ckpt_pkg::*;

`ifdef RENAME_COMMIT_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  dinstr_t    dinstr_i;
  p_reg_t     p_commit_i;
  p_reg_t     p_free_i;
  br_result_t br_result_i;
  rinstr_t    rinstr_o;
  logic       rn_full_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0][5:0] map;
    logic [63:0]      alloc;
  } ck_t;

  logic [31:0][5:0] mmap;
  logic [63:0]      mfree;
  logic [63:0]      mready;
  ck_t              mq [$];

  rename_ckpt dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .dinstr_i   (dinstr_i),
    .p_commit_i (p_commit_i),
    .p_free_i   (p_free_i),
    .br_result_i(br_result_i),
    .rinstr_o   (rinstr_o),
    .rn_full_o  (rn_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic dinstr_t mk(input logic v, input logic rdv, input int rd,
                                 input logic s1v, input int s1, input logic s2v, input int s2,
                                 input logic br);
    dinstr_t t;
    t.valid     = v;
    t.rd.valid  = rdv;
    t.rd.idx    = 5'(rd);
    t.rs1.valid = s1v;
    t.rs1.idx   = 5'(s1);
    t.rs2.valid = s2v;
    t.rs2.idx   = 5'(s2);
    t.is_branch = br;
    return t;
  endfunction

  function automatic p_reg_t pr(input logic v, input int idx);
    p_reg_t p;
    p.valid = v;
    p.idx   = 6'(idx);
    return p;
  endfunction

  task automatic idle();
    dinstr_i    = '0;
    p_commit_i  = '0;
    p_free_i    = '0;
    br_result_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle();
    tick();
    rst_i = 1'b0;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 64; i++) begin
      if (mfree[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit can_free(input int c);
    if (mfree[c]) return 1'b0;
    for (int a = 0; a < 32; a++) begin
      if (int'(mmap[a]) == c) return 1'b0;
    end
    foreach (mq[k]) begin
      if (mq[k].alloc[c]) return 1'b0;
      for (int a = 0; a < 32; a++) begin
        if (int'(mq[k].map[a]) == c) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  initial begin
    bit   full, miss, acc;
    int   a, c, exp_idx;
    logic exp_rdy;

    idle();
    rst_i    = 1'b1;
    dinstr_i = mk(1, 1, 1, 1, 2, 1, 3, 0);
    #2;
    chk("rst_valid", rinstr_o.valid, 0);
    chk("rst_full", rn_full_o, 1);
    tick();
    tick();
    rst_i = 1'b0;
    idle();
    #1;
    chk("post_rst_full", rn_full_o, 0);

    // First rename after reset
    dinstr_i = mk(1, 1, 1, 1, 2, 1, 3, 0);
    #1;
    chk("a_valid", rinstr_o.valid, 1);
    chk("a_rd_valid", rinstr_o.rd.valid, 1);
    chk("a_rd_idx", rinstr_o.rd.idx, 32);
    chk("a_rs1_idx", rinstr_o.rs1.idx, 2);
    chk("a_rs1_rdy", rinstr_o.rs1.ready, 1);
    chk("a_rs2_idx", rinstr_o.rs2.idx, 3);
    chk("a_rs2_rdy", rinstr_o.rs2.ready, 1);
    tick();

    // rd == rs reads the old mapping; writeback bypass on same cycle
    dinstr_i = mk(1, 1, 1, 1, 1, 0, 0, 0);
    #1;
    chk("b_rs1_idx", rinstr_o.rs1.idx, 32);
    chk("b_rs1_rdy", rinstr_o.rs1.ready, 0);
    chk("b_rd_idx", rinstr_o.rd.idx, 33);
    p_commit_i = pr(1, 32);
    #1;
    chk("b_bypass", rinstr_o.rs1.ready, BYP);
    tick();
    idle();

    dinstr_i = mk(1, 0, 0, 1, 0, 1, 1, 0);
    #1;
    chk("c_rd_valid", rinstr_o.rd.valid, 0);
    chk("c_rs1_idx", rinstr_o.rs1.idx, 0);
    chk("c_rs1_rdy", rinstr_o.rs1.ready, 1);
    chk("c_rs2_idx", rinstr_o.rs2.idx, 33);
    chk("c_rs2_rdy", rinstr_o.rs2.ready, 0);
    tick();

    dinstr_i   = mk(0, 1, 4, 1, 1, 0, 0, 0);
    p_commit_i = pr(1, 33);
    #1;
    chk("d_valid", rinstr_o.valid, 0);
    chk("d_rd_idx", rinstr_o.rd.idx, 34);
    tick();
    idle();
    dinstr_i = mk(0, 0, 0, 1, 1, 0, 0, 0);
    #1;
    chk("d_commit_rdy", rinstr_o.rs1.ready, 1);

    // Free-list exhaustion
    do_reset();
    for (int i = 0; i < 32; i++) begin
      dinstr_i = mk(1, 1, (i % 31) + 1, 0, 0, 0, 0, 0);
      #1;
      chk("exh_rd_idx", rinstr_o.rd.idx, 32 + i);
      tick();
    end
    dinstr_i = mk(1, 1, 3, 0, 0, 0, 0, 0);
    #1;
    chk("exh_full", rn_full_o, 1);
    chk("exh_valid", rinstr_o.valid, 0);
    idle();
    p_free_i = pr(1, 0);
    tick();
    idle();
    #1;
    chk("free_x0_full", rn_full_o, 1);
    p_free_i = pr(1, 40);
    tick();
    idle();
    #1;
    chk("free40_full", rn_full_o, 0);
    dinstr_i = mk(1, 1, 2, 0, 0, 0, 0, 0);
    #1;
    chk("free40_rd_idx", rinstr_o.rd.idx, 40);
    tick();

    // Mispredict recovery
    do_reset();
    dinstr_i = mk(1, 1, 7, 1, 5, 0, 0, 1);
    #1;
    chk("mp_br_rd_idx", rinstr_o.rd.idx, 32);
    tick();
    dinstr_i = mk(1, 1, 5, 0, 0, 0, 0, 0);
    #1;
    chk("mp_rd_idx", rinstr_o.rd.idx, 33);
    tick();
    dinstr_i    = mk(1, 1, 6, 1, 5, 0, 0, 0);
    br_result_i = '{valid: 1'b1, hit: 1'b0};
    #1;
    chk("mp_squash", rinstr_o.valid, 0);
    tick();
    idle();
    dinstr_i = mk(1, 1, 6, 1, 5, 1, 7, 0);
    #1;
    chk("mp_rs1_idx", rinstr_o.rs1.idx, 5);
    chk("mp_rs1_rdy", rinstr_o.rs1.ready, 1);
    chk("mp_rs2_idx", rinstr_o.rs2.idx, 32);
    chk("mp_rs2_rdy", rinstr_o.rs2.ready, 0);
    chk("mp_rd_idx_reuse", rinstr_o.rd.idx, 33);
    chk("mp_full", rn_full_o, 0);
    tick();

    // Checkpoint limit, hit handling, pop+push
    for (int i = 0; i < 4; i++) begin
      dinstr_i = mk(1, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("cl_not_full", rn_full_o, 0);
      tick();
    end
    idle();
    #1;
    chk("cl_full", rn_full_o, 1);
    dinstr_i    = mk(1, 0, 0, 0, 0, 0, 0, 1);
    br_result_i = '{valid: 1'b1, hit: 1'b1};
    #1;
    chk("cl_hit_full_valid", rinstr_o.valid, 0);
    tick();
    idle();
    #1;
    chk("cl_after_hit", rn_full_o, 0);
    dinstr_i    = mk(1, 1, 8, 0, 0, 0, 0, 1);
    br_result_i = '{valid: 1'b1, hit: 1'b1};
    #1;
    chk("pp_valid", rinstr_o.valid, 1);
    chk("pp_rd_idx", rinstr_o.rd.idx, 34);
    tick();
    idle();
    #1;
    chk("pp_full", rn_full_o, 0);
    dinstr_i = mk(1, 1, 9, 0, 0, 0, 0, 0);
    #1;
    chk("pp_rd9_idx", rinstr_o.rd.idx, 35);
    tick();
    dinstr_i = mk(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
    #1;
    chk("pp_full_again", rn_full_o, 1);
    br_result_i = '{valid: 1'b1, hit: 1'b0};
    tick();
    idle();
    dinstr_i = mk(1, 1, 10, 1, 8, 1, 9, 0);
    #1;
    chk("rec_rs1_idx", rinstr_o.rs1.idx, 8);
    chk("rec_rs1_rdy", rinstr_o.rs1.ready, 1);
    chk("rec_rs2_idx", rinstr_o.rs2.idx, 9);
    chk("rec_rd_idx", rinstr_o.rd.idx, 34);
    chk("rec_full", rn_full_o, 0);
    tick();
    dinstr_i = mk(0, 0, 0, 1, 6, 0, 0, 0);
    #1;
    chk("rec_rs6_idx", rinstr_o.rs1.idx, 33);
    chk("rec_rs6_rdy", rinstr_o.rs1.ready, 0);

    // Reset asserted mid-cycle
    dinstr_i = mk(1, 1, 3, 1, 10, 0, 0, 0);
    rst_i    = 1'b1;
    #1;
    chk("mr_valid", rinstr_o.valid, 0);
    chk("mr_full", rn_full_o, 1);
    tick();
    rst_i    = 1'b0;
    dinstr_i = mk(1, 1, 3, 1, 10, 0, 0, 0);
    #1;
    chk("mr_rs1_idx", rinstr_o.rs1.idx, 10);
    chk("mr_rd_idx", rinstr_o.rd.idx, 32);

    // Random run against the scoreboard model
    do_reset();
    mmap   = identity_map();
    mfree  = {32'hFFFF_FFFF, 32'h0};
    mready = '1;
    mq.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      idle();
      full = (mfree == '0) || (mq.size() == 4);
      if (!full && $urandom_range(0, 9) < 7) begin
        dinstr_i = mk(1, $urandom_range(0, 3) != 0, $urandom_range(0, 31),
                      $urandom_range(0, 1), $urandom_range(0, 31),
                      $urandom_range(0, 1), $urandom_range(0, 31),
                      $urandom_range(0, 4) == 0);
      end
      if (mq.size() > 0 && $urandom_range(0, 9) < 2) begin
        br_result_i = '{valid: 1'b1, hit: ($urandom_range(0, 3) != 0)};
      end
      c = $urandom_range(1, 63);
      if ($urandom_range(0, 9) < 4 && !mfree[c] && !mready[c]) p_commit_i = pr(1, c);
      c = $urandom_range(1, 63);
      if ($urandom_range(0, 9) < 5 && can_free(c)) p_free_i = pr(1, c);
      #1;
      miss = br_result_i.valid && !br_result_i.hit;
      acc  = dinstr_i.valid && !full && !miss;
      chk("rnd_full", rn_full_o, full);
      chk("rnd_valid", rinstr_o.valid, acc);
      if (dinstr_i.valid) begin
        exp_idx = (dinstr_i.rs1.idx == 0) ? 0 : int'(mmap[dinstr_i.rs1.idx]);
        exp_rdy = (exp_idx == 0) || mready[exp_idx] ||
                  (BYP && p_commit_i.valid && int'(p_commit_i.idx) == exp_idx);
        chk("rnd_rs1_idx", rinstr_o.rs1.idx, exp_idx);
        chk("rnd_rs1_rdy", rinstr_o.rs1.ready, exp_rdy);
        exp_idx = (dinstr_i.rs2.idx == 0) ? 0 : int'(mmap[dinstr_i.rs2.idx]);
        exp_rdy = (exp_idx == 0) || mready[exp_idx] ||
                  (BYP && p_commit_i.valid && int'(p_commit_i.idx) == exp_idx);
        chk("rnd_rs2_idx", rinstr_o.rs2.idx, exp_idx);
        chk("rnd_rs2_rdy", rinstr_o.rs2.ready, exp_rdy);
        chk("rnd_rd_valid", rinstr_o.rd.valid, dinstr_i.rd.valid && dinstr_i.rd.idx != 0);
        if (dinstr_i.rd.valid && dinstr_i.rd.idx != 0) begin
          chk("rnd_rd_idx", rinstr_o.rd.idx, lowest_free());
        end
      end
      if (acc && dinstr_i.rd.valid && dinstr_i.rd.idx != 0) begin
        a                      = lowest_free();
        mfree[a]               = 1'b0;
        mready[a]              = 1'b0;
        mmap[dinstr_i.rd.idx]  = 6'(a);
        foreach (mq[k]) mq[k].alloc[a] = 1'b1;
      end
      if (br_result_i.valid && br_result_i.hit) void'(mq.pop_front());
      if (acc && dinstr_i.is_branch) mq.push_back('{map: mmap, alloc: 64'h0});
      if (miss) begin
        mmap = mq[0].map;
        foreach (mq[k]) begin
          mfree  = mfree | mq[k].alloc;
          mready = mready | mq[k].alloc;
        end
        mq.delete();
      end
      if (p_commit_i.valid) mready[p_commit_i.idx] = 1'b1;
      if (p_free_i.valid) mfree[p_free_i.idx] = 1'b1;
      tick();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
